// File: rtl/mips_pkg.sv
// Constants shared by the MIPS register bank and the destination-register selector.
// The $29/$31 indices here must stay identical to the ones that selector decodes.
package mips_pkg;

   localparam int DATA_W       = 32;
   localparam int REG_ADDR_W   = 5;
   localparam int NUM_REGS     = 1 << REG_ADDR_W;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
   localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

   localparam int SP_RESET_VAL = 227;

endpackage

// File: rtl/reg_bank_rd_port.sv
// One combinational read port: optional same-cycle write bypass, then $0 forced to zero.
// The zero forcing is applied last, so a bypass can never leak a value onto index 0.
module reg_bank_rd_port #(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int BYPASS = 0
) (
   input  logic [mips_pkg::REG_ADDR_W-1:0] rd_idx,
   input  logic [DATA_W-1:0]               rd_raw,
   input  logic                            wr_en,
   input  logic [mips_pkg::REG_ADDR_W-1:0] wr_idx,
   input  logic [DATA_W-1:0]               wr_data,
   output logic [DATA_W-1:0]               rd_data
);
   import mips_pkg::*;

   always_comb begin
      rd_data = rd_raw;
      if ((BYPASS != 0) && wr_en && (wr_idx == rd_idx)) begin
         rd_data = wr_data;
      end
      if (rd_idx == REG_ZERO) begin
         rd_data = '0;
      end
   end

endmodule

// File: rtl/reg_bank_wb.sv
// 32 x DATA_W MIPS register file: two async read ports, one sync write port,
// an unbypassed debug read and a saturating count of committed writes.
module reg_bank_wb #(
   parameter int DATA_W   = mips_pkg::DATA_W,
   parameter int SP_RESET = mips_pkg::SP_RESET_VAL,
   parameter int BYPASS   = 0,
   parameter int CNT_W    = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            reg_write,
   input  logic [mips_pkg::REG_ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0]               write_data,
   input  logic [mips_pkg::REG_ADDR_W-1:0] read_reg1,
   input  logic [mips_pkg::REG_ADDR_W-1:0] read_reg2,
   output logic [DATA_W-1:0]               read_data1,
   output logic [DATA_W-1:0]               read_data2,
   input  logic [mips_pkg::REG_ADDR_W-1:0] dbg_sel,
   output logic [DATA_W-1:0]               dbg_data,
   output logic [CNT_W-1:0]                wr_count
);
   import mips_pkg::*;

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [CNT_W-1:0]  cnt_q;
   logic              commit;
   logic              wr_live;

   // Writes to $0 are dropped entirely, including from the commit count.
   assign commit  = reg_write && (write_reg != REG_ZERO);
   // Bypass is only meaningful when the edge will actually perform the write.
   assign wr_live = reg_write && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         regs[REG_SP] <= DATA_W'(SP_RESET);
         cnt_q        <= '0;
      end else if (commit) begin
         regs[write_reg] <= write_data;
         if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign wr_count = cnt_q;
   assign dbg_data = regs[dbg_sel];

   reg_bank_rd_port #(
      .DATA_W (DATA_W),
      .BYPASS (BYPASS)
   ) u_rd_port1 (
      .rd_idx  (read_reg1),
      .rd_raw  (regs[read_reg1]),
      .wr_en   (wr_live),
      .wr_idx  (write_reg),
      .wr_data (write_data),
      .rd_data (read_data1)
   );

   reg_bank_rd_port #(
      .DATA_W (DATA_W),
      .BYPASS (BYPASS)
   ) u_rd_port2 (
      .rd_idx  (read_reg2),
      .rd_raw  (regs[read_reg2]),
      .wr_en   (wr_live),
      .wr_idx  (write_reg),
      .wr_data (write_data),
      .rd_data (read_data2)
   );

endmodule

// File: tb/tb_reg_bank_wb.sv
// Bench for reg_bank_wb: a BYPASS=0/CNT_W=16 copy and a BYPASS=1/CNT_W=4 copy share one stimulus stream.
// The driver queues expected port values; a negedge monitor pops and compares them.
module tb_reg_bank_wb;

   logic        clk;
   logic        reset;
   logic        reg_write;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic [4:0]  read_reg1;
   logic [4:0]  read_reg2;
   logic [4:0]  dbg_sel;

   logic [31:0] d0_rd1, d0_rd2, d0_dbg;
   logic [31:0] d1_rd1, d1_rd2, d1_dbg;
   logic [15:0] d0_cnt;
   logic [3:0]  d1_cnt;

   logic [31:0] exp_q[$];
   int          code_q[$];
   int          id_q[$];
   int          checks;
   int          errors;
   int          next_id;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   reg_bank_wb #(.DATA_W(32), .SP_RESET(227), .BYPASS(0), .CNT_W(16)) dut0 (
      .clk        (clk),
      .reset      (reset),
      .reg_write  (reg_write),
      .write_reg  (write_reg),
      .write_data (write_data),
      .read_reg1  (read_reg1),
      .read_reg2  (read_reg2),
      .read_data1 (d0_rd1),
      .read_data2 (d0_rd2),
      .dbg_sel    (dbg_sel),
      .dbg_data   (d0_dbg),
      .wr_count   (d0_cnt)
   );

   reg_bank_wb #(.DATA_W(32), .SP_RESET(227), .BYPASS(1), .CNT_W(4)) dut1 (
      .clk        (clk),
      .reset      (reset),
      .reg_write  (reg_write),
      .write_reg  (write_reg),
      .write_data (write_data),
      .read_reg1  (read_reg1),
      .read_reg2  (read_reg2),
      .read_data1 (d1_rd1),
      .read_data2 (d1_rd2),
      .dbg_sel    (dbg_sel),
      .dbg_data   (d1_dbg),
      .wr_count   (d1_cnt)
   );

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // code: 0 d0.rd1, 1 d0.rd2, 2 d0.dbg, 3 d0.cnt, 4 d1.rd1, 5 d1.rd2, 6 d1.dbg, 7 d1.cnt
   task automatic expect_port(input int code, input logic [31:0] val);
      exp_q.push_back(val);
      code_q.push_back(code);
      id_q.push_back(next_id);
      next_id++;
   endtask

   task automatic expect_both(input int code, input logic [31:0] val);
      expect_port(code, val);
      expect_port(code + 4, val);
   endtask

   task automatic do_write(input logic [4:0] idx, input logic [31:0] data);
      reg_write  = 1'b1;
      write_reg  = idx;
      write_data = data;
      cyc();
      reg_write  = 1'b0;
   endtask

   // ---------------- scoreboard monitor ----------------
   function automatic logic [31:0] actual(input int code);
      case (code)
         0: return d0_rd1;
         1: return d0_rd2;
         2: return d0_dbg;
         3: return {16'd0, d0_cnt};
         4: return d1_rd1;
         5: return d1_rd2;
         6: return d1_dbg;
         default: return {28'd0, d1_cnt};
      endcase
   endfunction

   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         logic [31:0] e;
         logic [31:0] a;
         int          c;
         int          id;
         e  = exp_q.pop_front();
         c  = code_q.pop_front();
         id = id_q.pop_front();
         a  = actual(c);
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL chk%0d port%0d: got %h want %h", id, c, a, e);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      checks     = 0;
      errors     = 0;
      next_id    = 0;
      reset      = 1'b1;
      reg_write  = 1'b0;
      write_reg  = '0;
      write_data = '0;
      read_reg1  = '0;
      read_reg2  = '0;
      dbg_sel    = '0;
      cyc();
      cyc();
      reset = 1'b0;

      // Post-reset image: zero everywhere except $29.
      for (int i = 0; i < 32; i++) begin
         read_reg1 = 5'(i);
         read_reg2 = 5'(31 - i);
         dbg_sel   = 5'(i);
         expect_both(0, (i == 29) ? 32'd227 : 32'd0);
         expect_both(1, ((31 - i) == 29) ? 32'd227 : 32'd0);
         expect_both(2, (i == 29) ? 32'd227 : 32'd0);
         if (i == 0) expect_both(3, 32'd0);
         cyc();
      end

      // Same-cycle read of the register being written.
      reg_write  = 1'b1;
      write_reg  = 5'd8;
      write_data = 32'hDEAD_BEEF;
      read_reg1  = 5'd8;
      dbg_sel    = 5'd8;
      expect_port(0, 32'd0);
      expect_port(4, 32'hDEAD_BEEF);
      expect_both(2, 32'd0);
      cyc();
      reg_write = 1'b0;
      expect_both(0, 32'hDEAD_BEEF);
      expect_both(2, 32'hDEAD_BEEF);
      expect_both(3, 32'd1);
      cyc();

      // $0 is hardwired: write is ignored, bypass never applies.
      reg_write  = 1'b1;
      write_reg  = 5'd0;
      write_data = 32'h1234_5678;
      read_reg2  = 5'd0;
      expect_both(1, 32'd0);
      cyc();
      reg_write = 1'b0;
      expect_both(1, 32'd0);
      expect_both(3, 32'd1);
      dbg_sel = 5'd0;
      expect_both(2, 32'd0);
      cyc();

      // jal-style $31 write, stack pointer write, plus $5 for the reset test.
      do_write(5'd31, 32'h0000_0040);
      do_write(5'd29, 32'h0000_00E0);
      do_write(5'd5,  32'h0000_0055);
      read_reg1 = 5'd31;
      read_reg2 = 5'd29;
      dbg_sel   = 5'd5;
      expect_both(0, 32'h40);
      expect_both(1, 32'hE0);
      expect_both(2, 32'h55);
      expect_both(3, 32'd4);
      cyc();

      // Reset dominates a concurrent write.
      reset      = 1'b1;
      reg_write  = 1'b1;
      write_reg  = 5'd5;
      write_data = 32'd7;
      cyc();
      reset     = 1'b0;
      reg_write = 1'b0;
      read_reg1 = 5'd5;
      read_reg2 = 5'd29;
      dbg_sel   = 5'd31;
      expect_both(0, 32'd0);
      expect_both(1, 32'd227);
      expect_both(2, 32'd0);
      expect_both(3, 32'd0);
      cyc();

      // Counter saturation: 20 commits, 4-bit copy stops at 15 but still stores.
      for (int i = 0; i < 20; i++) begin
         do_write(5'(i + 1), 32'h100 + 32'(i));
      end
      read_reg1 = 5'd20;
      read_reg2 = 5'd1;
      dbg_sel   = 5'd17;
      expect_both(0, 32'h113);
      expect_both(1, 32'h100);
      expect_both(2, 32'h110);
      expect_port(3, 32'd20);
      expect_port(7, 32'd15);
      cyc();

      cyc();
      cyc();
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_bank_wb.md
Name: reg_bank_wb

Overview:
- 32 x 32-bit MIPS general-purpose register file.
- Sits directly downstream of the destination-register selector:
  - its write_reg input is the 5-bit destination chosen from rt (inst[20:16]), rd (inst[15:11]), $31 (ra), $29 (sp) or rs (inst[25:21]).
  - its read ports feed the A/B operand registers of the multicycle datapath.
- Provides two asynchronous read ports, one synchronous write port, a debug read port and a saturating count of committed writes.

Parameters:
- DATA_W, 32, register width in bits.
- SP_RESET, 227, value loaded into $29 (stack pointer) on reset.
- BYPASS, 0; 1 = a read port returns write_data when it addresses the register being written this cycle.
- CNT_W, 16, width of wr_count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- reg_write  in  1  write enable from control unit.
- write_reg  in  5  destination register index, from the destination-register selector.
- write_data  in  DATA_W  data to write, from the write-back data selector.
- read_reg1  in  5  source index for port 1 (rs).
- read_reg2  in  5  source index for port 2 (rt).
- read_data1  out  DATA_W  contents of read_reg1.
- read_data2  out  DATA_W  contents of read_reg2.
- dbg_sel  in  5  debug read index.
- dbg_data  out  DATA_W  contents of dbg_sel; never bypassed.
- wr_count  out  CNT_W  number of committed writes since reset, saturating.

Behaviour:
- Clock and reset
  - One clock, clk.
  - Reset is synchronous and active-high: sampled only on the rising edge of clk.
- Storage: regs[0..31], DATA_W bits each.
- Reset (rising edge with reset=1)
  - All regs <= 0, except regs[29] <= SP_RESET.
  - wr_count <= 0.
  - Reset dominates: a concurrent reg_write is discarded and does not count.
- Post-reset output values
  - read_data1, read_data2 and dbg_data read 0 for every index except 29, which reads 227.
  - wr_count = 0.
- Write (rising edge, reset=0, reg_write=1)
  - write_reg != 0: regs[write_reg] <= write_data, and wr_count <= wr_count+1 unless wr_count = all-ones (saturates, no wrap).
  - write_reg = 0: no state change and wr_count unchanged. $0 is hardwired zero.
- Reads
  - Purely combinational from regs, zero cycles latency.
  - Index 0 always returns 0, regardless of any write attempt.
- Same-cycle read/write of the same nonzero index
  - BYPASS=0: read returns the old value during the write cycle; the new value is visible after the edge.
  - BYPASS=1: read_data1/2 return write_data combinationally whenever reg_write=1, reset=0 and the index matches.
  - BYPASS=1, index 0: bypass never applies; returns 0.
- Both read ports may address the same register; each port is independent.
- reset high on an edge mid-instruction: state is cleared regardless of the multicycle FSM step. No partial write survives.
- X/Z on write_reg when reg_write=0: no effect.

Decomposition:
- Shared package (mips_pkg):
  - DATA_W=32, REG_ADDR_W=5.
  - REG_ZERO=5'd0, REG_SP=5'd29, REG_RA=5'd31.
  - SP_RESET_VAL=227.
  - These are the same constants the destination-register selector uses for $29/$31.
- One natural sub-module: reg_bank_rd_port.
  - Combinational: index-0 forcing plus optional bypass compare/mux.
  - Instantiated twice (ports 1, 2).
  - dbg_data uses a plain indexed read, not this sub-module.

Test Plan:
- Reset then read all 32 indices via read_reg1 and dbg_sel -> 0 everywhere except index 29 = 227; wr_count=0.
- reg_write=1, write_reg=8, write_data=0xDEADBEEF, read_reg1=8 in the same cycle:
  - BYPASS=0 -> read_data1=0 that cycle, 0xDEADBEEF next cycle.
  - BYPASS=1 -> 0xDEADBEEF in the same cycle.
  - Both cases -> wr_count=1.
- Write 0x12345678 to index 0, then read_reg2=0 -> read_data2=0; wr_count unchanged; BYPASS=1 also returns 0.
- Write 31 <- 0x00000040 (jal path) and 29 <- 0x000000E0, read both ports simultaneously -> read_data1=0x40, read_data2=0xE0.
- With regs populated, assert reset together with reg_write=1, write_reg=5, write_data=7 -> regs[5]=0, regs[29]=227, wr_count=0.
- CNT_W=4 build, 20 writes to nonzero indices -> wr_count stops at 15; further writes still update registers.
